// File: rtl/dcache_if.sv
// CPU request/response and memory refill/writeback signals of the data cache.
// slave: cache side. master: pipeline + memory model side.
interface dcache_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic                  req_valid;
  logic                  req_write;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_wstrb;
  logic                  req_ready;
  logic                  resp_valid;
  logic [DATA_W-1:0]     resp_rdata;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_ready;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, mem_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, mem_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_assoc.sv
// Two-way set-associative write-back / write-allocate data cache, one word
// per line, one LRU bit per set, byte-masked stores.
// Optional macro DCACHE_PERF_CNT_EN: hit/miss/writeback counters; otherwise
// the counter ports are tied to zero.
module dcache_assoc #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int SETS   = 128
) (
  input  logic        clk,
  input  logic        reset,
  dcache_if.slave     bus,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
  output logic [31:0] wb_count
);
  localparam int OFF_W = $clog2(DATA_W/8);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int STB_W = DATA_W/8;

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, RESPOND} state_t;

  state_t              state_q;
  logic [SETS-1:0]     valid_q [2];
  logic [SETS-1:0]     dirty_q [2];
  logic [SETS-1:0]     lru_q;
  logic [TAG_W-1:0]    tag_q   [2][SETS];
  logic [DATA_W-1:0]   data_q  [2][SETS];

  // latched miss context
  logic [IDX_W-1:0]    a_idx_q;
  logic [TAG_W-1:0]    a_tag_q;
  logic [DATA_W-1:0]   a_wdata_q;
  logic [STB_W-1:0]    a_wstrb_q;
  logic                a_we_q;
  logic                vic_q;

  logic                resp_valid_q, mem_req_q, mem_we_q;
  logic [DATA_W-1:0]   resp_rdata_q, mem_wdata_q;
  logic [ADDR_W-1:0]   mem_addr_q;

  logic [IDX_W-1:0]    idx;
  logic [TAG_W-1:0]    tag;
  logic [1:0]          hit_w;
  logic                hit_any, hw, vic, accept;
  logic [DATA_W-1:0]   refill_line;
  logic                unused_addr_lo;

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                              input logic [DATA_W-1:0] wd,
                                              input logic [STB_W-1:0]  st);
    merge = old;
    for (int b = 0; b < STB_W; b++)
      if (st[b]) merge[b*8 +: 8] = wd[b*8 +: 8];
  endfunction

  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] t,
                                                  input logic [IDX_W-1:0] i);
    line_addr = ADDR_W'({t, i}) << OFF_W;
  endfunction

  assign idx            = bus.req_addr[OFF_W+IDX_W-1:OFF_W];
  assign tag            = bus.req_addr[ADDR_W-1:OFF_W+IDX_W];
  assign unused_addr_lo = ^bus.req_addr[OFF_W-1:0];

  for (genvar w = 0; w < 2; w++) begin : g_way
    assign hit_w[w] = valid_q[w][idx] && (tag_q[w][idx] == tag);
  end

  assign hit_any     = |hit_w;
  assign hw          = ~hit_w[0];
  // first invalid way wins, else LRU names the victim
  assign vic         = !valid_q[0][idx] ? 1'b0 : (!valid_q[1][idx] ? 1'b1 : lru_q[idx]);
  assign accept      = bus.req_valid && (state_q == IDLE);
  assign refill_line = a_we_q ? merge(bus.mem_rdata, a_wdata_q, a_wstrb_q) : bus.mem_rdata;

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;

  // tag/data arrays: no reset, written by store hits and refills
  always_ff @(posedge clk) begin
    if (!reset && accept && hit_any && bus.req_write)
      data_q[hw][idx] <= merge(data_q[hw][idx], bus.req_wdata, bus.req_wstrb);
    if (!reset && state_q == REFILL && bus.mem_ready) begin
      data_q[vic_q][a_idx_q] <= refill_line;
      tag_q[vic_q][a_idx_q]  <= a_tag_q;
    end
  end

  // control FSM with line state bits and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      valid_q      <= '{default: '0};
      dirty_q      <= '{default: '0};
      lru_q        <= '0;
      a_idx_q      <= '0;
      a_tag_q      <= '0;
      a_wdata_q    <= '0;
      a_wstrb_q    <= '0;
      a_we_q       <= 1'b0;
      vic_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: if (accept) begin
          if (hit_any) begin
            if (bus.req_write) dirty_q[hw][idx] <= 1'b1;
            else               resp_rdata_q     <= data_q[hw][idx];
            lru_q[idx]   <= ~hw;
            resp_valid_q <= 1'b1;
          end else begin
            a_idx_q   <= idx;
            a_tag_q   <= tag;
            a_wdata_q <= bus.req_wdata;
            a_wstrb_q <= bus.req_wstrb;
            a_we_q    <= bus.req_write;
            vic_q     <= vic;
            mem_req_q <= 1'b1;
            if (valid_q[vic][idx] && dirty_q[vic][idx]) begin
              state_q     <= WRITEBACK;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= line_addr(tag_q[vic][idx], idx);
              mem_wdata_q <= data_q[vic][idx];
            end else begin
              state_q    <= REFILL;
              mem_we_q   <= 1'b0;
              mem_addr_q <= line_addr(tag, idx);
            end
          end
        end
        WRITEBACK: if (bus.mem_ready) begin
          dirty_q[vic_q][a_idx_q] <= 1'b0;
          mem_we_q                <= 1'b0;
          mem_addr_q              <= line_addr(a_tag_q, a_idx_q);
          state_q                 <= REFILL;
        end
        REFILL: if (bus.mem_ready) begin
          valid_q[vic_q][a_idx_q] <= 1'b1;
          dirty_q[vic_q][a_idx_q] <= a_we_q;
          lru_q[a_idx_q]          <= ~vic_q;
          mem_req_q               <= 1'b0;
          resp_rdata_q            <= refill_line;
          resp_valid_q            <= 1'b1;
          state_q                 <= RESPOND;
        end
        RESPOND: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;

  // free-running event counters, wrap at 2^32
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      if (accept && hit_any)                           hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (accept && !hit_any)                          miss_cnt_q <= miss_cnt_q + 32'd1;
      if (state_q == WRITEBACK && bus.mem_ready)       wb_cnt_q   <= wb_cnt_q + 32'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
  assign wb_count   = wb_cnt_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
  assign wb_count   = '0;
`endif
endmodule

// File: tb/tb_dcache_assoc.sv
// Directed bench for dcache_assoc: cold miss with a stalled refill, hits,
// byte-masked store, LRU dirty eviction, reset mid-refill, counters.
module tb_dcache_assoc;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] hit_count, miss_count, wb_count;
  int          checks = 0;
  int          errors = 0;

  dcache_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  dcache_assoc #(.ADDR_W(64), .DATA_W(64), .SETS(128)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic wr, input logic [63:0] addr, input logic [63:0] wd, input logic [7:0] st);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_wstrb = st;
    tick();
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
  endtask

  task automatic mem_done(input logic [63:0] rd);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = rd;
    tick();
    bus.mem_ready = 1'b0;
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0;   bus.req_wstrb = '0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    #3;
    check("rst_ready", bus.req_ready, 1);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_hit_cnt", hit_count, 0);
    tick();
    reset = 1'b0;
    tick();

    // cold load miss on 0x100, memory stalls 10 cycles
    req(0, 64'h100, 0, 0);
    check("miss_mem_req", bus.mem_req, 1);
    check("miss_mem_we", bus.mem_we, 0);
    check("miss_mem_addr", bus.mem_addr, 64'h100);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_mem_req", bus.mem_req, 1);
      check("stall_mem_addr", bus.mem_addr, 64'h100);
      check("stall_ready", bus.req_ready, 0);
      check("stall_resp_valid", bus.resp_valid, 0);
    end
    mem_done(64'hAAAA);
    check("refill_resp_valid", bus.resp_valid, 1);
    check("refill_rdata", bus.resp_rdata, 64'hAAAA);
    check("refill_mem_req_drop", bus.mem_req, 0);
    check("respond_ready", bus.req_ready, 0);
    tick();
    check("after_resp_valid", bus.resp_valid, 0);
    check("after_ready", bus.req_ready, 1);

    // repeat load hits in one cycle
    req(0, 64'h100, 0, 0);
    check("hit_resp_valid", bus.resp_valid, 1);
    check("hit_rdata", bus.resp_rdata, 64'hAAAA);
    check("hit_no_mem", bus.mem_req, 0);

    // store hit low word, then back-to-back load sees merged data
    req(1, 64'h100, 64'h11223344, 8'h0F);
    check("st_hit_valid", bus.resp_valid, 1);
    check("st_no_mem", bus.mem_req, 0);
    req(0, 64'h100, 0, 0);
    check("ld_after_st_valid", bus.resp_valid, 1);
    check("ld_after_st_rdata", bus.resp_rdata, 64'h0000_0000_1122_3344);

    // set 0: dirty 0x000 by a full store miss
    req(1, 64'h000, 64'hD0D0, 8'hFF);
    check("st_miss_we", bus.mem_we, 0);
    check("st_miss_addr", bus.mem_addr, 64'h000);
    mem_done(64'h5555);
    check("st_miss_rdata", bus.resp_rdata, 64'hD0D0);
    tick();
    // 0x400 fills the invalid way 1
    req(0, 64'h400, 0, 0);
    check("ld400_we", bus.mem_we, 0);
    check("ld400_addr", bus.mem_addr, 64'h400);
    mem_done(64'h4444);
    check("ld400_rdata", bus.resp_rdata, 64'h4444);
    tick();
    // 0x800 evicts LRU way 0 (dirty 0x000): writeback, then refill
    req(0, 64'h800, 0, 0);
    check("wb_mem_req", bus.mem_req, 1);
    check("wb_we", bus.mem_we, 1);
    check("wb_addr", bus.mem_addr, 64'h000);
    check("wb_wdata", bus.mem_wdata, 64'hD0D0);
    mem_done(64'h0);
    check("wb2rf_mem_req", bus.mem_req, 1);
    check("wb2rf_we", bus.mem_we, 0);
    check("wb2rf_addr", bus.mem_addr, 64'h800);
    check("wb2rf_resp_valid", bus.resp_valid, 0);
    mem_done(64'h8888);
    check("ld800_valid", bus.resp_valid, 1);
    check("ld800_rdata", bus.resp_rdata, 64'h8888);
    tick();
    // 0x400 survived in way 1
    req(0, 64'h400, 0, 0);
    check("hit400_valid", bus.resp_valid, 1);
    check("hit400_rdata", bus.resp_rdata, 64'h4444);
    check("hit400_no_mem", bus.mem_req, 0);

`ifdef DCACHE_PERF_CNT_EN
    check("hit_count", hit_count, 4);
    check("miss_count", miss_count, 4);
    check("wb_count", wb_count, 1);
`else
    check("hit_count_off", hit_count, 0);
    check("miss_count_off", miss_count, 0);
    check("wb_count_off", wb_count, 0);
`endif

    // reset in the middle of a refill of 0xC00
    req(0, 64'hC00, 0, 0);
    check("c00_mem_req", bus.mem_req, 1);
    check("c00_addr", bus.mem_addr, 64'hC00);
    reset = 1'b1;
    #2;
    check("midrst_mem_req", bus.mem_req, 0);
    check("midrst_ready", bus.req_ready, 1);
    tick();
    reset = 1'b0;
    tick();
    req(0, 64'hC00, 0, 0);
    check("post_rst_miss", bus.mem_req, 1);
    check("post_rst_addr", bus.mem_addr, 64'hC00);
    mem_done(64'hCCCC);
    check("post_rst_rdata", bus.resp_rdata, 64'hCCCC);
    tick();
    check("final_ready", bus.req_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
